// File: rtl/sram_cmd_sequencer.sv
// In-order command front-end for the sram controller: buffers host read/write
// commands, issues them one at a time as single-cycle strobes, returns read data.
module sram_cmd_sequencer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [ADDR_W-1:0]        cmd_addr,
    input  logic [DATA_W-1:0]        cmd_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic [ADDR_W-1:0]        rsp_addr,
    output logic                     ctl_write,
    output logic                     ctl_read,
    output logic [ADDR_W-1:0]        ctl_address,
    output logic [DATA_W-1:0]        ctl_data_write,
    input  logic [DATA_W-1:0]        ctl_data_read,
    input  logic                     ctl_ready,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fill
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int FILL_W  = PTR_W + 1;
    localparam int ENTRY_W = 1 + ADDR_W + DATA_W;
    localparam logic [FILL_W-1:0] FIFO_FULL = FILL_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    logic [ENTRY_W-1:0] fifo_mem [DEPTH];

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic                op_write_q, op_write_d;
    logic [ADDR_W-1:0]   op_addr_q, op_addr_d;
    logic [DATA_W-1:0]   op_wdata_q, op_wdata_d;
    logic                ctl_write_q, ctl_write_d;
    logic                ctl_read_q, ctl_read_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [ADDR_W-1:0]   rsp_addr_q, rsp_addr_d;

    logic                push;
    logic                pop;
    logic                launch;
    logic [ENTRY_W-1:0]  head;
    logic                head_write;

    // No bypass: a full FIFO refuses even when a pop happens in the same cycle.
    assign cmd_ready  = !reset && (fill_q != FIFO_FULL);
    assign push       = cmd_valid && cmd_ready;
    assign head       = fifo_mem[rd_ptr_q];
    assign head_write = head[ENTRY_W-1];

    // A read at the head waits for the single response slot; writes behind it wait too.
    assign launch = (state_q == S_IDLE) && (fill_q != '0) && ctl_ready &&
                    (head_write || !rsp_valid_q);
    assign pop    = launch;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fill_d      = fill_q;
        op_write_d  = op_write_q;
        op_addr_d   = op_addr_q;
        op_wdata_d  = op_wdata_q;
        ctl_write_d = 1'b0;
        ctl_read_d  = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_addr_d  = rsp_addr_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   fill_d = fill_q + FILL_W'(1);
            2'b01:   fill_d = fill_q - FILL_W'(1);
            default: fill_d = fill_q;
        endcase

        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (launch) begin
                    op_write_d  = head_write;
                    op_addr_d   = head[DATA_W +: ADDR_W];
                    op_wdata_d  = head[DATA_W-1:0];
                    ctl_write_d = head_write;
                    ctl_read_d  = !head_write;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (ctl_ready) begin
                    if (!op_write_q) begin
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = ctl_data_read;
                        rsp_addr_d  = op_addr_q;
                    end
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            op_write_q  <= 1'b0;
            op_addr_q   <= '0;
            op_wdata_q  <= '0;
            ctl_write_q <= 1'b0;
            ctl_read_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_q      <= fill_d;
            op_write_q  <= op_write_d;
            op_addr_q   <= op_addr_d;
            op_wdata_q  <= op_wdata_d;
            ctl_write_q <= ctl_write_d;
            ctl_read_q  <= ctl_read_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_addr_q  <= rsp_addr_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and fill count.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {cmd_write, cmd_addr, cmd_wdata};
        end
    end

    assign ctl_write      = ctl_write_q;
    assign ctl_read       = ctl_read_q;
    assign ctl_address    = op_addr_q;
    assign ctl_data_write = op_wdata_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_addr       = rsp_addr_q;
    assign fill           = fill_q;
    assign busy           = (fill_q != '0) || (state_q != S_IDLE);

endmodule

// File: tb/tb_sram_cmd_sequencer.sv
// Bench for sram_cmd_sequencer: behavioural SRAM controller, directed scenarios
// and a randomized phase, all checked against an in-order transaction model.
module tb_sram_cmd_sequencer;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 4;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } rsp_t;

    logic              clock;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic [ADDR_W-1:0] rsp_addr;
    logic              ctl_write;
    logic              ctl_read;
    logic [ADDR_W-1:0] ctl_address;
    logic [DATA_W-1:0] ctl_data_write;
    logic [DATA_W-1:0] ctl_data_read;
    logic              ctl_ready;
    logic              busy;
    logic [2:0]        fill;

    logic rspForce;
    logic rspRandom;
    logic rspCoin;

    int checkCount = 0;
    int failCount  = 0;

    sram_cmd_sequencer #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_addr      (rsp_addr),
        .ctl_write     (ctl_write),
        .ctl_read      (ctl_read),
        .ctl_address   (ctl_address),
        .ctl_data_write(ctl_data_write),
        .ctl_data_read (ctl_data_read),
        .ctl_ready     (ctl_ready),
        .busy          (busy),
        .fill          (fill)
    );

    assign rsp_ready = rspForce | (rspRandom & rspCoin);

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        rspCoin = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            rspCoin = 1'($urandom_range(0, 1));
        end
    end

    // Controller model: ready drops the cycle after a strobe and returns two cycles later.
    logic [DATA_W-1:0] sramMem [256];
    logic [DATA_W-1:0] shadowMem [256];
    logic [DATA_W-1:0] sramReadData;
    int                ctlCnt = 0;

    assign ctl_ready     = (ctlCnt == 0);
    assign ctl_data_read = sramReadData;

    initial begin
        sramReadData <= '0;
        for (int i = 0; i < 256; i++) begin
            sramMem[i]   <= DATA_W'(i * 5 + 3);
            shadowMem[i]  = DATA_W'(i * 5 + 3);
        end
    end

    always @(posedge clock) begin
        if (reset) begin
            ctlCnt <= 0;
        end else if (ctl_write || ctl_read) begin
            ctlCnt <= 2;
            if (ctl_write) sramMem[ctl_address] <= ctl_data_write;
            else           sramReadData <= sramMem[ctl_address];
        end else if (ctlCnt > 0) begin
            ctlCnt <= ctlCnt - 1;
        end
    end

    task checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at t=%0t", tag, observed, expected, $time);
        end
    endtask

    // Reference model: queued commands, single in-flight op, one response slot.
    cmd_t              cmdQ[$];
    rsp_t              respQ[$];
    logic              inFlight      = 1'b0;
    logic              curWr         = 1'b0;
    logic [ADDR_W-1:0] curAddr       = '0;
    logic [DATA_W-1:0] curData       = '0;
    logic              modelRspValid = 1'b0;
    logic              expectStrobe  = 1'b0;
    logic              prevReset     = 1'b1;

    always @(negedge clock) begin : monitor
        logic strobe;
        logic modelReady;
        cmd_t c;
        rsp_t r;
        strobe = ctl_write | ctl_read;
        checkOutput("strobe_timing", strobe, expectStrobe);
        checkOutput("strobe_both", ctl_write & ctl_read, 0);
        checkOutput("strobe_not_ready", strobe & ~ctl_ready, 0);
        if (strobe) begin
            if (cmdQ.size() == 0) begin
                checkOutput("issue_unexpected", strobe, 0);
            end else begin
                c = cmdQ.pop_front();
                checkOutput("issue_kind", {ctl_write, ctl_read}, c.wr ? 2'b10 : 2'b01);
                curWr    = c.wr;
                curAddr  = c.addr;
                curData  = c.data;
                inFlight = 1'b1;
            end
        end
        modelReady = !reset && (cmdQ.size() != DEPTH);
        checkOutput("fill", fill, cmdQ.size());
        checkOutput("busy", busy, (cmdQ.size() != 0) || inFlight);
        checkOutput("cmd_ready", cmd_ready, modelReady);
        checkOutput("rsp_valid", rsp_valid, modelRspValid);
        checkOutput("ctl_address", ctl_address, curAddr);
        checkOutput("ctl_data_write", ctl_data_write, curData);
        if (prevReset) begin
            checkOutput("reset_rsp_rdata", rsp_rdata, 0);
            checkOutput("reset_rsp_addr", rsp_addr, 0);
        end
        if (reset) begin
            cmdQ.delete();
            respQ.delete();
            inFlight      = 1'b0;
            curWr         = 1'b0;
            curAddr       = '0;
            curData       = '0;
            modelRspValid = 1'b0;
            expectStrobe  = 1'b0;
        end else begin
            expectStrobe = !inFlight && (cmdQ.size() != 0) && ctl_ready &&
                           (cmdQ[0].wr || !modelRspValid);
            if (modelRspValid && rsp_ready) begin
                if (respQ.size() == 0) begin
                    checkOutput("rsp_unexpected", rsp_valid, 0);
                end else begin
                    r = respQ.pop_front();
                    checkOutput("rsp_rdata", rsp_rdata, r.data);
                    checkOutput("rsp_addr", rsp_addr, r.addr);
                end
                modelRspValid = 1'b0;
            end
            if (inFlight && !strobe && ctl_ready) begin
                if (!curWr) modelRspValid = 1'b1;
                inFlight = 1'b0;
            end
            if (cmd_valid && modelReady) begin
                cmdQ.push_back('{cmd_write, cmd_addr, cmd_wdata});
                if (cmd_write) shadowMem[cmd_addr] = cmd_wdata;
                else           respQ.push_back('{cmd_addr, shadowMem[cmd_addr]});
            end
        end
        prevReset = reset;
    end

    task applyStimulus(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bit ok;
        ok        = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clock);
            if (cmd_ready) ok = 1'b1;
            @(posedge clock);
            #1;
        end
        cmd_valid = 1'b0;
        cmd_wdata = DATA_W'($urandom);
        if (!ok) checkOutput("push_timeout", ok, 1);
    endtask

    task waitForStrobe(input logic wantRead, input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clock);
            if (wantRead ? ctl_read : (ctl_write | ctl_read)) ok = 1'b1;
        end
        if (!ok) checkOutput(tag, ok, 1);
    endtask

    task waitIdle(input string tag);
        bit ok;
        ok       = 1'b0;
        rspForce = 1'b1;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clock);
            if (!busy && !rsp_valid) ok = 1'b1;
        end
        if (!ok) checkOutput(tag, ok, 1);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #400000;
        checkOutput("watchdog", 0, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

    initial begin
        int  n;
        bit  done;
        logic [DATA_W-1:0] d;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rspForce  = 1'b1;
        rspRandom = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset_cmd_ready", cmd_ready, 0);
        reset = 1'b0;

        $display("[TB] single write");
        applyStimulus(1'b1, 8'h3C, 4'hA);
        waitForStrobe(1'b0, "t1_strobe_timeout");
        checkOutput("t1_ctl_write", ctl_write, 1);
        n = 0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clock);
            n++;
            if (n <= 3) begin
                checkOutput("t1_write_pulse", ctl_write, 0);
                checkOutput("t1_addr_hold", ctl_address, 8'h3C);
                checkOutput("t1_data_hold", ctl_data_write, 4'hA);
            end
            if (!busy) done = 1'b1;
        end
        checkOutput("t1_busy_fall_cycle", n, 4);
        checkOutput("t1_fill_empty", fill, 0);
        @(posedge clock);
        #1;

        $display("[TB] write then read");
        applyStimulus(1'b1, 8'h10, 4'h5);
        applyStimulus(1'b0, 8'h10, 4'h0);
        waitForStrobe(1'b1, "t2_strobe_timeout");
        n = 0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clock);
            n++;
            if (rsp_valid) done = 1'b1;
        end
        checkOutput("t2_rsp_latency", n, 4);
        checkOutput("t2_rsp_rdata", rsp_rdata, 4'h5);
        checkOutput("t2_rsp_addr", rsp_addr, 8'h10);
        waitIdle("t2_idle_timeout");

        $display("[TB] fifo full with response backpressure");
        rspForce = 1'b0;
        applyStimulus(1'b0, 8'h20, 4'h0);
        done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge clock);
            if (rsp_valid) done = 1'b1;
        end
        if (!done) checkOutput("t3_rsp_timeout", done, 1);
        @(posedge clock);
        #1;
        applyStimulus(1'b0, 8'h21, 4'h0);
        applyStimulus(1'b1, 8'h22, 4'h9);
        applyStimulus(1'b0, 8'h22, 4'h0);
        applyStimulus(1'b1, 8'h23, 4'h6);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'h24;
        cmd_wdata = 4'h3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checkOutput("t3_full_cmd_ready", cmd_ready, 0);
            checkOutput("t3_full_fill", fill, 4);
            checkOutput("t3_blocked_read", ctl_read, 0);
        end
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        rspForce  = 1'b1;
        @(posedge clock);
        #1;
        rspForce = 1'b0;
        n = 0;
        done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            @(negedge clock);
            n++;
            if (ctl_read) done = 1'b1;
        end
        checkOutput("t3_launch_after_rsp", n, 2);
        @(posedge clock);
        #1;
        applyStimulus(1'b1, 8'h24, 4'h3);
        waitIdle("t3_idle_timeout");

        $display("[TB] reset mid-operation");
        applyStimulus(1'b0, 8'h30, 4'h0);
        applyStimulus(1'b0, 8'h31, 4'h0);
        applyStimulus(1'b0, 8'h32, 4'h0);
        applyStimulus(1'b0, 8'h33, 4'h0);
        checkOutput("t4_fill_before_reset", fill, 3);
        checkOutput("t4_busy_before_reset", busy, 1);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checkOutput("t4_fill_after", fill, 0);
            checkOutput("t4_rsp_valid_after", rsp_valid, 0);
            checkOutput("t4_no_strobe", ctl_write | ctl_read, 0);
        end
        @(posedge clock);
        #1;
        applyStimulus(1'b1, 8'h40, 4'hC);
        waitForStrobe(1'b0, "t4_strobe_timeout");
        checkOutput("t4_new_write", ctl_write, 1);
        @(posedge clock);
        #1;
        applyStimulus(1'b0, 8'h40, 4'h0);
        waitIdle("t4_idle_timeout");

        $display("[TB] wrap-around stream");
        for (int i = 0; i < 5; i++) begin
            d = DATA_W'($urandom);
            applyStimulus(1'b1, 8'h50 + 8'(i), d);
            applyStimulus(1'b0, 8'h50 + 8'(i), 4'h0);
        end
        waitIdle("t5_idle_timeout");

        $display("[TB] randomized traffic");
        rspForce  = 1'b0;
        rspRandom = 1'b1;
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 8'h60 + 8'($urandom_range(0, 7)), DATA_W'($urandom));
            repeat ($urandom_range(0, 3)) begin
                @(posedge clock);
                #1;
            end
        end
        rspRandom = 1'b0;
        waitIdle("t6_idle_timeout");

        @(negedge clock);
        checkOutput("final_fill", fill, 0);
        checkOutput("final_busy", busy, 0);
        checkOutput("final_pending_responses", respQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/sram_cmd_sequencer.md
# sram_cmd_sequencer

Command front-end that sits directly upstream of the `sram` controller. Accepts read/write commands from a host over a valid/ready interface and buffers them in a small in-order FIFO. Issues each one to the controller as a single-cycle `write`/`read` strobe and holds address/data stable until the controller returns to ready. Returns read data to the host over a valid/ready response interface.

## Interface
- `DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `ADDR_W`, 8: address width; matches the controller.
- `DATA_W`, 4: data width; matches the controller.

- `clock`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high. Shared with the controller.
- `cmd_valid`  in  1  host command valid.
- `cmd_ready`  out  1  FIFO can accept a command.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  ADDR_W  command address.
- `cmd_wdata`  in  DATA_W  write data; ignored for reads.
- `rsp_valid`  out  1  read response valid.
- `rsp_ready`  in  1  host accepts response.
- `rsp_rdata`  out  DATA_W  read data.
- `rsp_addr`  out  ADDR_W  address of the read being returned.
- `ctl_write`  out  1  to controller `write`.
- `ctl_read`  out  1  to controller `read`.
- `ctl_address`  out  ADDR_W  to controller `address`.
- `ctl_data_write`  out  DATA_W  to controller `data_write`.
- `ctl_data_read`  in  DATA_W  from controller `data_read`.
- `ctl_ready`  in  1  from controller `ready`.
- `busy`  out  1  high when the FIFO is non-empty or the state is not S_IDLE.
- `fill`  out  clog2(DEPTH)+1  FIFO occupancy.

## Operation
- **FIFO**
  - Push on `cmd_valid && cmd_ready`.
  - `cmd_ready = !reset && fill != DEPTH`. No bypass: a full FIFO refuses the command even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full leaves `fill` unchanged.
  - Read/write pointers wrap modulo DEPTH.
- **Launch condition (in S_IDLE):** FIFO non-empty && `ctl_ready` && (head is a write || `!rsp_valid`).
- **State machine**
  - **S_IDLE:** when the launch condition holds, load the op registers (kind, addr, wdata) from the head, pop the FIFO, go to S_ISSUE.
  - **S_ISSUE:** assert `ctl_write` or `ctl_read` for exactly this one cycle, per the op kind. Next state is S_WAIT unconditionally.
  - **S_WAIT:** strobes low. Stay until `ctl_ready == 1`.
    - On that cycle, for a read: capture `ctl_data_read` into `rsp_rdata` and op addr into `rsp_addr`, set `rsp_valid`.
    - Go to S_IDLE.
- `ctl_address`/`ctl_data_write` are driven from the op registers. They change only on a load in S_IDLE and are stable from S_ISSUE through the end of S_WAIT.
- **Response:** `rsp_valid` clears on `rsp_valid && rsp_ready`. `rsp_rdata`/`rsp_addr` hold while valid.
- **Ordering:** strictly in order. A read at the head blocked by a pending response also blocks any writes behind it (head-of-line).
- At most one command is in flight at the controller. At most one read response is outstanding.
- **Reset values:**
  - `cmd_ready` = 0 while reset is high.
  - `rsp_valid`, `ctl_write`, `ctl_read` = 0.
  - `ctl_address`, `ctl_data_write`, `rsp_rdata`, `rsp_addr` = 0.
  - `fill` = 0, `busy` = 0, state S_IDLE.
- **Reset mid-operation:** FIFO flushed, in-flight op abandoned, pending response dropped. No strobe is asserted in the cycle after reset deasserts.

## Timing
- Push at edge E: entry is visible at head the cycle after E. The launch decision is made that cycle.
- Let T be the S_ISSUE cycle:
  - The controller is in setup at T+1, in its write/read state at T+2, and returns `ctl_ready = 1` at T+3.
  - Read data is captured at the end of T+3. `rsp_valid` = 1 at T+4.
  - S_IDLE at T+4. The next launch has S_ISSUE at T+5.
- Sustained throughput: 1 command per 5 cycles.
- Empty FIFO, push at edge E to `rsp_valid`: E+5 edges (rsp_valid visible in the cycle after the 5th edge).
- `ctl_write`/`ctl_read` are registered. Never both high. Never high while `ctl_ready == 0`.

## Test plan
- **Single write:** push write addr 0x3C, data 0xA with FIFO empty. Require:
  - `ctl_write` high for exactly one cycle.
  - `ctl_address` = 0x3C and `ctl_data_write` = 0xA held for 4 cycles.
  - `fill` returns to 0; `busy` falls at T+4.
- **Write then read:** write 0x5 to 0x10, then read 0x10, against an SRAM model. Require:
  - `rsp_valid` at T+4 of the read.
  - `rsp_rdata` = 0x5, `rsp_addr` = 0x10.
- **FIFO full:** push 5 commands back-to-back with `DEPTH` = 4. Require:
  - `cmd_ready` low when `fill` = 4 and the 5th command is stalled.
  - Pops every 5 cycles; all commands reach the controller in order.
- **Response backpressure:** two reads followed by a write, with `rsp_ready` held low. Require:
  - The second read is not issued and the write waits behind it.
  - After `rsp_ready` pulses, the second read launches within 2 cycles.
- **Reset mid-op:** assert reset at T+2 of a read with 3 entries queued. Require:
  - `fill` = 0, `rsp_valid` = 0, no strobe after release.
  - A new write issues normally.
- **Wrap-around:** stream 10 alternating writes/reads through `DEPTH` = 4. Require:
  - Pointers wrap.
  - Every read returns the data written by the preceding write to the same address.
